// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divider operand-issue stage.
//   state_t   : sequencer FSM states
//   operand_t : signed dividend/divisor pair as stored in the operand FIFO
//   ERR_*     : bit positions inside the 2-bit error field
package div_seq_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ERR_W   = 2;
    localparam int unsigned ERR_DEG = 0;
    localparam int unsigned ERR_TMO = 1;

    localparam logic [DATA_W-1:0] MOST_NEG = 8'h80;
    localparam logic [DATA_W-1:0] ZERO_VAL = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        HOLD
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } operand_t;

    // Operand pairs the shift divider forces to a zero quotient.
    function automatic logic is_degenerate(input operand_t op);
        return (op.b == ZERO_VAL) || (op.a == ZERO_VAL) ||
               (op.a == MOST_NEG) || (op.b == MOST_NEG);
    endfunction

endpackage

// File: rtl/div_op_sequencer_if.sv
// Stream and divider-side signals of the operand-issue stage.
//   in_*  : operand pair stream into the sequencer (valid/ready)
//   div_* : operand/start/done/quotient link to the shift divider
//   out_* : quotient result stream (valid/ready) with error flags
// master = environment side, slave = sequencer side.
interface div_op_sequencer_if;
    import div_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DATA_W-1:0] div_a;
    logic [DATA_W-1:0] div_b;
    logic              div_start;
    logic              div_done;
    logic [DATA_W-1:0] div_q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_q;
    logic [ERR_W-1:0]  out_err;

    modport master (
        output in_valid, in_a, in_b, div_done, div_q, out_ready,
        input  in_ready, div_a, div_b, div_start, out_valid, out_q, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, div_done, div_q, out_ready,
        output in_ready, div_a, div_b, div_start, out_valid, out_q, out_err
    );

endinterface

// File: rtl/div_seq_fifo.sv
// Synchronous operand FIFO with registered read data.
//   push/wr_data : write when not full (no push-through when full)
//   pop          : read when not empty; rd_data updates on the pop edge and
//                  then holds until the next pop
//   full/empty   : from extended-pointer compare
// clk, rst (synchronous, active-low).
module div_seq_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and read-data registers; pointers wrap modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/div_op_sequencer.sv
// Operand-issue stage in front of the 8-bit signed shift divider.
// Buffers operand pairs, issues one at a time with a start pulse, waits for
// completion (with a watchdog) and returns the quotient plus error flags.
//   clk, rst : clock, synchronous active-low reset
//   bus      : in_* operand stream, div_* divider link, out_* result stream
module div_op_sequencer
    import div_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic               clk,
    input  logic               rst,
    div_op_sequencer_if.slave  bus
);

    localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;

    state_t            state;
    logic [WD_W-1:0]   wd;
    logic              deg;
    logic              start_q;
    logic              valid_q;
    logic [DATA_W-1:0] q_q;
    logic [ERR_W-1:0]  err_q;
    operand_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign pop = (state == IDLE) && !fifo_empty;

    // The FIFO's registered read data doubles as the held divider operands.
    div_seq_fifo #(
        .WIDTH ($bits(operand_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.in_valid),
        .wr_data ({bus.in_a, bus.in_b}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sequencer FSM, watchdog and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            wd      <= '0;
            deg     <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            q_q     <= '0;
            err_q   <= '0;
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        start_q <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    // Operands became visible this cycle, so classify them here.
                    wd    <= '0;
                    deg   <= is_degenerate(head);
                    state <= WAIT;
                end
                WAIT: begin
                    // A done in the timeout cycle still counts as a normal completion.
                    if (bus.div_done) begin
                        q_q            <= bus.div_q;
                        err_q[ERR_TMO] <= 1'b0;
                        err_q[ERR_DEG] <= deg;
                        valid_q        <= 1'b1;
                        state          <= HOLD;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        q_q            <= '0;
                        err_q[ERR_TMO] <= 1'b1;
                        err_q[ERR_DEG] <= deg;
                        valid_q        <= 1'b1;
                        state          <= HOLD;
                    end else if (wd != '1) begin
                        wd <= wd + WD_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.div_a     = head.a;
    assign bus.div_b     = head.b;
    assign bus.div_start = start_q;
    assign bus.out_valid = valid_q;
    assign bus.out_q     = q_q;
    assign bus.out_err   = err_q;

endmodule

// File: doc/div_op_sequencer.md
# div_op_sequencer

Operand-issue stage that sits directly upstream of the 8-bit signed shift divider and also collects its quotient. It accepts signed operand pairs on a valid/ready stream and buffers them in a small FIFO. It presents one pair at a time to the divider, holding it stable, and pulses `div_start`. It then waits for `div_done`, captures the quotient and returns it on a valid/ready output stream with error flags.

## Interface
- `FIFO_DEPTH`, default 2: operand FIFO entries; power of two, ≥2.
- `TIMEOUT`, default 32: cycles allowed in WAIT before the timeout error fires; must exceed the divider latency (17).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO not full.
- `in_a` in 8: signed dividend.
- `in_b` in 8: signed divisor.
- `div_a` out 8: dividend to the divider; registered, stable from START until the response is captured.
- `div_b` out 8: divisor to the divider; registered, same stability rule.
- `div_start` out 1: one-cycle start pulse to the divider.
- `div_done` in 1: one-cycle completion from the divider.
- `div_q` in 8: divider quotient, valid while `div_done`=1.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_q` out 8: quotient.
- `out_err` out 2: [0] degenerate operand (`b`=0, or `a`/`b` = 8'h00/8'h80 as the divider zeroes these); [1] timeout.

## Operation
- Reset (`rst`=0 at clock edge):
  - state IDLE; FIFO emptied.
  - `div_start`=0, `out_valid`=0, `out_q`=0, `out_err`=0, `div_a`=`div_b`=0.
  - `in_ready`=1 after the reset edge.
- Input handshake: push when `in_valid & in_ready`. `in_ready` = !full; no push-through when full, even if a pop occurs that cycle.
- FSM states: IDLE, START, WAIT, HOLD.
  - IDLE: if FIFO not empty, pop. Load `div_a`/`div_b`. Compute `deg`=degenerate predicate. Go to START.
  - START: `div_start`=1 this cycle only. Clear watchdog. Go to WAIT.
  - WAIT, on `div_done`=1: `out_q`←`div_q`; `out_err`←{0,`deg`}; go to HOLD.
  - WAIT, on watchdog = `TIMEOUT`-1 without `div_done`: `out_q`←0; `out_err`←{1,`deg`}; go to HOLD.
  - WAIT otherwise: watchdog increments.
  - HOLD: `out_valid`=1. On `out_ready`, go to IDLE. The next pop happens in that IDLE cycle at the earliest.
- `out_q` is `div_q` passed unchanged; no sign correction here. A degenerate pair is still issued to the divider, so the divider's 0 result is returned with `out_err[0]`=1.
- `div_done` is ignored in IDLE, START and HOLD. This covers late dones after a timeout and dones arriving after reset.
- `div_done` and timeout in the same cycle: `div_done` wins and `out_err[1]`=0.
- `out_q`/`out_err` hold their value in HOLD regardless of the inputs.
- Reset mid-operation: everything returns to IDLE immediately and queued pairs are lost. No start is issued for one cycle after reset is released.
- Watchdog width: clog2(`TIMEOUT`)+1 bits; saturates; never wraps.
- FIFO pointers: log2(`FIFO_DEPTH`)+1 bits; full/empty from the MSB compare; wrap-around is natural modulo.

## Timing
- Accept at cycle 0:
  - cycle 1 pop (IDLE), if the FSM is idle;
  - cycle 2 `div_start`;
  - divider asserts `div_done` at cycle 2+L (L=17 nominal);
  - `out_valid` from cycle 3+L (20 nominal).
- Throughput: one result per L+3 cycles, plus consumer stall cycles. No overlap of divider operations.
- `div_a`/`div_b` change only in the IDLE pop cycle, taking effect the following cycle.
- `in_ready` deasserts the cycle after the FIFO reaches `FIFO_DEPTH` entries.

## Structure
- Package `div_seq_pkg`:
  - state enum (IDLE, START, WAIT, HOLD);
  - `ERR_DEG`=0 and `ERR_TMO`=1 bit indices;
  - localparam constants 8'h80 (`MOST_NEG`) and 8'h00.
- Sub-module `div_seq_fifo`:
  - synchronous FIFO, parameter `WIDTH`=16 and `DEPTH`;
  - push/pop/full/empty, registered read data;
  - same clock and active-low synchronous reset.
- The top holds the FSM, the operand/result registers and the watchdog.

## Test plan
- Bench divider model: returns trunc(a/b) signed after 17 cycles. It returns 0 when `b`=0 or either operand is 0/8'h80. Check `div_a`/`div_b` stability every cycle in WAIT.
- Accept (100,7), `out_ready`=1 → `div_start` at cycle 2; `out_q`=8'd14, `out_err`=0, `out_valid` at cycle 20.
- Back-to-back (-100,7), (50,-5), (-9,-3) with `out_ready` held low for 5 cycles on each result:
  - results 8'hF2, 8'hF6, 8'h03 in order;
  - `in_ready` drops after 2 queued entries.
- (5,0) → `out_q`=0, `out_err`=2'b01; (8'h80,3) → `out_q`=0, `out_err`=2'b01.
- Model never asserts done → `out_valid` at cycle 3+`TIMEOUT`, `out_q`=0, `out_err`=2'b10. Then inject a stray `div_done` during HOLD → no effect.
- `rst`=0 during WAIT with 2 entries queued:
  - next cycle: IDLE, `in_ready`=1, `out_valid`=0, `div_start`=0;
  - a subsequent (20,4) returns 8'd5.
